fp_mul_round_pack: RTL
======================

// Module: fp_mul_round_pack
// PURPOSE
//  Final stage of the pipelined FP32 multiplier, directly downstream of the 32x32 Wallace-tree
//  mantissa multiplier. Takes the raw 64-bit mantissa product, plus sign, exponent and
//  special-case flags delay-matched alongside it. Normalizes, rounds to nearest-even, handles
//  exponent overflow/underflow and special operands, and packs an IEEE-754 single result.
//  Two-stage pipeline, one result per clock, no backpressure.
// PARAMETERS
//  EXP_W   8   exponent field width
//  MAN_W   23  stored fraction width (significand = MAN_W+1 bits)
//  PROD_W  64  product input width; only bits [2*MAN_W+1:0] carry data, upper bits ignored
// PORTS
//  clk        in   1       rising-edge clock
//  clear      in   1       synchronous, active-high reset
//  in_valid   in   1       prod/sign/exp/flags valid this cycle
//  prod       in   PROD_W  significand product {1,fa}*{1,fb}; leading one at bit 47 or 46
//  sign_in    in   1       sa ^ sb
//  exp_in     in   EXP_W+2 two's-complement ea+eb-127 (biased domain, before normalize)
//  is_nan     in   1       either operand NaN
//  is_inf     in   1       either operand infinite
//  is_zero    in   1       either operand zero or denormal (denormals flushed upstream)
//  out_valid  out  1       result/flags valid
//  result     out  32      packed {sign, exp[7:0], frac[22:0]}
//  overflow   out  1       finite result exceeded max exponent -> infinity
//  underflow  out  1       result exponent <= 0 -> flushed to signed zero
//  inexact    out  1       discarded product bits nonzero (or overflow/underflow)
//  invalid    out  1       NaN operand or inf*0
// BEHAVIOUR
//  Reset: clear=1 at an edge -> both stage registers and all outputs 0 on the next cycle,
//   including valids. In-flight operations are discarded; no partial result is ever emitted.
//  Latency: inputs sampled at edge N with in_valid=1 -> out_valid=1 and result during cycle
//   after edge N+2. Full throughput; back-to-back valids each produce one result, in order.
//  Outputs are registered. When out_valid=0, result and all flags hold 0.
//  Stage 1 (normalize):
//   - If prod[47]=1: sig=prod[47:24], G=prod[23], S=|prod[22:0], e=exp_in+1.
//   - Else: sig=prod[46:23], G=prod[22], S=|prod[21:0], e=exp_in.
//   - Register sig, G, S, LSB=sig[0], e, sign and the special flags.
//  Stage 2 (round/pack):
//   - up = G & (S | LSB). Then sig' = sig + up, computed 25 bits wide.
//   - If sig'[24]=1: frac=0, e=e+1. Otherwise frac=sig'[22:0].
//   - inexact_raw = G | S.
//   - Range check after rounding:
//     - e >= 255: result={sign,8'hFF,23'd0}, overflow=1, inexact=1.
//     - e <= 0: result={sign,31'd0}, underflow=1, inexact=1. Flush only; no denormal output.
//     - Otherwise: result={sign,e[7:0],frac}, inexact=inexact_raw.
//  Special priority, highest first; each overrides the arithmetic path and clears
//   overflow/underflow/inexact:
//   1. is_nan | (is_inf & is_zero): result=32'h7FC00000, invalid=1.
//   2. is_inf: result={sign,8'hFF,23'd0}.
//   3. is_zero: result={sign,31'd0}.
//  exp_in arithmetic is signed on EXP_W+2 bits. No wrap is allowed: exponent sums from
//   -127 to 382 must classify correctly.
//  prod with neither bit 47 nor bit 46 set is only legal with is_zero/is_nan/is_inf set.
//   In that case the output is defined by the special path.
// TESTING
//  1.0*1.0: prod=64'h4000_0000_0000, exp_in=127 -> 32'h3F800000, all flags 0, 2 cycles later.
//  1.5*1.5: prod=64'h9000_0000_0000, exp_in=127 -> 32'h40100000 (normalize via bit 47).
//  RNE ties: prod=64'h4000_0040_0000 -> 32'h3F800000 with inexact=1;
//   prod=64'h4000_00C0_0000 -> 32'h3F800002 with inexact=1.
//  Rounding carry-out: prod=64'h7FFF_FFC0_0000, exp_in=127 -> 32'h40000000, inexact=1.
//  Range: exp_in=254 with prod bit47 -> 32'h7F800000, overflow=1;
//   exp_in=0 with prod bit46, sign_in=1 -> 32'h80000000, underflow=1.
//  Specials and reset: is_inf&is_zero -> 32'h7FC00000, invalid=1;
//   clear asserted with 2 ops in flight -> out_valid=0 for the next 2 cycles;
//   10 back-to-back random ops match the reference model in order.

Source files
------------

// File: rtl/fp_mul_round_pack.sv
// FP32 multiplier back end: normalize, round-to-nearest-even, range/special handling, pack.
// Register stages: normalize -> round -> packed output. Result is visible two edges after the sample edge.
module fp_mul_round_pack #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MAN_W  = 23,
  parameter int unsigned PROD_W = 64
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [PROD_W-1:0]      prod,
  input  logic                   sign_in,
  input  logic [EXP_W+1:0]       exp_in,
  input  logic                   is_nan,
  input  logic                   is_inf,
  input  logic                   is_zero,
  output logic                   out_valid,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact,
  output logic                   invalid
);

  localparam int unsigned TOP = 2 * MAN_W + 1;
  localparam int unsigned SW  = MAN_W + 1;
  localparam int unsigned EW  = EXP_W + 3;
  localparam int unsigned RW  = EXP_W + MAN_W + 1;

  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic [RW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Stage 1 registers
  logic                 s1_valid, s1_g, s1_s, s1_sign, s1_nan, s1_inf, s1_zero;
  logic [SW-1:0]        s1_sig;
  logic signed [EW-1:0] s1_e;

  // Stage 2 registers
  logic                 s2_valid, s2_inexact, s2_sign, s2_nan, s2_inf, s2_zero;
  logic [MAN_W-1:0]     s2_frac;
  logic signed [EW-1:0] s2_e;

  // Normalize: shift left by one when the leading one sits at TOP-1; exponent widened so sums never wrap
  logic [TOP:0]         norm_c;
  logic signed [EW-1:0] e_norm_c;
  assign norm_c   = prod[TOP] ? prod[TOP:0] : {prod[TOP-1:0], 1'b0};
  assign e_norm_c = $signed({exp_in[EXP_W+1], exp_in}) + $signed({{(EW-1){1'b0}}, prod[TOP]});

  // Round to nearest even; a carry out of the significand bumps the exponent and leaves a zero fraction
  logic                 up_c;
  logic [SW:0]          sum_c;
  logic [MAN_W-1:0]     frac_c;
  logic signed [EW-1:0] e_rnd_c;
  assign up_c    = s1_g & (s1_s | s1_sig[0]);
  assign sum_c   = {1'b0, s1_sig} + (SW+1)'(up_c);
  assign frac_c  = sum_c[SW] ? '0 : sum_c[MAN_W-1:0];
  assign e_rnd_c = s1_e + $signed({{(EW-1){1'b0}}, sum_c[SW]});

  // Product bits above the significand field and the hidden bit carry no information here
  logic unused_bits;
  assign unused_bits = ^{prod[PROD_W-1:TOP+1], sum_c[MAN_W]};

  // Stage 1: capture normalized significand, guard/sticky, exponent and operand flags
  always_ff @(posedge clk) begin
    if (clear) begin
      s1_valid <= 1'b0;
      s1_sig   <= '0;
      s1_g     <= 1'b0;
      s1_s     <= 1'b0;
      s1_e     <= '0;
      s1_sign  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_sig   <= norm_c[TOP -: SW];
      s1_g     <= norm_c[TOP-SW];
      s1_s     <= |norm_c[TOP-SW-1:0];
      s1_e     <= e_norm_c;
      s1_sign  <= sign_in;
      s1_nan   <= is_nan;
      s1_inf   <= is_inf;
      s1_zero  <= is_zero;
    end
  end

  // Stage 2: capture rounded fraction, post-round exponent and inexactness
  always_ff @(posedge clk) begin
    if (clear) begin
      s2_valid   <= 1'b0;
      s2_frac    <= '0;
      s2_e       <= '0;
      s2_inexact <= 1'b0;
      s2_sign    <= 1'b0;
      s2_nan     <= 1'b0;
      s2_inf     <= 1'b0;
      s2_zero    <= 1'b0;
    end else begin
      s2_valid   <= s1_valid;
      s2_frac    <= frac_c;
      s2_e       <= e_rnd_c;
      s2_inexact <= s1_g | s1_s;
      s2_sign    <= s1_sign;
      s2_nan     <= s1_nan;
      s2_inf     <= s1_inf;
      s2_zero    <= s1_zero;
    end
  end

  // Pack: special operands first, then overflow/underflow range check, else normal result
  logic [RW-1:0] res_c;
  logic          ovf_c, unf_c, inx_c, inv_c;
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    unf_c = 1'b0;
    inx_c = 1'b0;
    inv_c = 1'b0;
    if (s2_valid) begin
      if (s2_nan | (s2_inf & s2_zero)) begin
        res_c = QNAN;
        inv_c = 1'b1;
      end else if (s2_inf) begin
        res_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (s2_zero) begin
        res_c = {s2_sign, {(RW-1){1'b0}}};
      end else if (s2_e >= E_MAX) begin
        res_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        ovf_c = 1'b1;
        inx_c = 1'b1;
      end else if (s2_e <= E_ZERO) begin
        res_c = {s2_sign, {(RW-1){1'b0}}};
        unf_c = 1'b1;
        inx_c = 1'b1;
      end else begin
        res_c = {s2_sign, s2_e[EXP_W-1:0], s2_frac};
        inx_c = s2_inexact;
      end
    end
  end

  // Output register; everything reads zero while out_valid is low
  always_ff @(posedge clk) begin
    if (clear) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      result    <= res_c;
      overflow  <= ovf_c;
      underflow <= unf_c;
      inexact   <= inx_c;
      invalid   <= inv_c;
    end
  end

endmodule
